// File: rtl/seq_int_div_if.sv
// Request/response bundle between the divide EU wrapper and the divider core.
// Latency: n/a (wiring only).
// Backpressure: master may pulse start only while busy is low; no other flow control.
interface seq_int_div_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            is_signed;
    logic            is_word;
    logic            busy;
    logic            ready;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    modport master (
        output start, op1, op2, is_signed, is_word,
        input  busy, ready, quo, rem
    );

    modport slave (
        input  start, op1, op2, is_signed, is_word,
        output busy, ready, quo, rem
    );
endinterface

// File: rtl/seq_int_div.sv
// Restoring radix-2 divider with RISC-V M semantics (DIV/DIVU/REM/REMU and W forms).
// Latency: XLEN+1 cycles (XLEN/2+1 in word mode), 1 cycle for divide-by-zero or signed overflow.
// Backpressure: start is ignored while busy; results are held until the next accepted start completes.
module seq_int_div #(
    parameter int XLEN = 64
) (
    input  logic         clk,
    input  logic         rst,
    seq_int_div_if.slave dif
);
    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] dvd_q, dvd_d;     // dividend magnitude, consumed MSB first
    logic [XLEN-1:0] dsr_q, dsr_d;     // divisor magnitude
    logic [XLEN-1:0] prem_q, prem_d;   // partial remainder (raw result for special cases)
    logic [XLEN-1:0] qacc_q, qacc_d;   // quotient accumulator (raw result for special cases)
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            word_q, word_d;
    logic            spec_q, spec_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic            ready_q, ready_d;

    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, most_neg;
    logic            a_neg, b_neg, div_zero, ovf;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] fix_q, fix_r;

    // Effective operands: width-adjusted, extended, and split into sign + magnitude.
    always_comb begin
        a_ext = dif.op1;
        b_ext = dif.op2;
        most_neg = {1'b1, {(XLEN-1){1'b0}}};
        if (dif.is_word) begin
            a_ext    = {{HALF{dif.is_signed & dif.op1[HALF-1]}}, dif.op1[HALF-1:0]};
            b_ext    = {{HALF{dif.is_signed & dif.op2[HALF-1]}}, dif.op2[HALF-1:0]};
            most_neg = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
        end
        a_neg    = dif.is_signed & a_ext[XLEN-1];
        b_neg    = dif.is_signed & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = dif.is_signed & (a_ext == most_neg) & (b_ext == '1);
    end

    // Next-state, iteration datapath and result fix-up.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        qacc_d  = qacc_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        word_d  = word_q;
        spec_d  = spec_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ready_d = 1'b0;
        trial   = {prem_q, dvd_q[XLEN-1]} - {1'b0, dsr_q};
        fix_q   = qacc_q;
        fix_r   = prem_q;

        case (state_q)
            IDLE: begin
                if (dif.start) begin
                    word_d = dif.is_word;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    dsr_d  = b_mag;
                    dvd_d  = dif.is_word ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
                    cnt_d  = dif.is_word ? CW'(HALF) : CW'(XLEN);
                    qacc_d = '0;
                    prem_d = '0;
                    spec_d = div_zero | ovf;
                    if (div_zero) begin
                        qacc_d  = '1;
                        prem_d  = a_ext;
                        state_d = FIX;
                    end else if (ovf) begin
                        qacc_d  = a_ext;
                        prem_d  = '0;
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dvd_d = {dvd_q[XLEN-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (!trial[XLEN]) begin
                    prem_d = trial[XLEN-1:0];
                    qacc_d = {qacc_q[XLEN-2:0], 1'b1};
                end else begin
                    prem_d = {prem_q[XLEN-2:0], dvd_q[XLEN-1]};
                    qacc_d = {qacc_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (!spec_q) begin
                    fix_q = negq_q ? -qacc_q : qacc_q;
                    fix_r = negr_q ? -prem_q : prem_q;
                end
                if (word_q) begin
                    fix_q = {{HALF{fix_q[HALF-1]}}, fix_q[HALF-1:0]};
                    fix_r = {{HALF{fix_r[HALF-1]}}, fix_r[HALF-1:0]};
                end
                quo_d   = fix_q;
                rem_d   = fix_r;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            qacc_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            word_q  <= 1'b0;
            spec_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            qacc_q  <= qacc_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            word_q  <= word_d;
            spec_q  <= spec_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ready_q <= ready_d;
        end
    end

    assign dif.busy  = (state_q != IDLE);
    assign dif.ready = ready_q;
    assign dif.quo   = quo_q;
    assign dif.rem   = rem_q;
endmodule

// File: tb/tb_seq_int_div.sv
// Directed bench for seq_int_div with an expected-result queue.
// Latency: checks accept-to-ready cycle counts per operation class.
// Backpressure: exercises ignored start while busy and back-to-back start in the ready cycle.
module tb_seq_int_div;
    logic clk;
    logic rst;

    seq_int_div_if #(.XLEN(64)) dif ();

    seq_int_div #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] last_q  = '0;
    logic [63:0] last_r  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, push its expectation, then wait for ready and score it.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic w, input logic [63:0] eq,
                          input logic [63:0] er, input int elat, input bit poke);
        exp_t e;
        int   lat;
        int   busy_err;
        bit   got;
        e.q = eq;
        e.r = er;
        e.lat = elat;
        sb.push_back(e);
        @(negedge clk);
        dif.start     = 1'b1;
        dif.op1       = a;
        dif.op2       = b;
        dif.is_signed = s;
        dif.is_word   = w;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.op1   = 64'hA5A5_5A5A_0F0F_F0F0;
        dif.op2   = 64'h3;
        chk({tag, "_held_quo"}, dif.quo, last_q);
        chk({tag, "_held_rem"}, dif.rem, last_r);
        chk({tag, "_ready_low"}, {63'b0, dif.ready}, 64'd0);
        lat = 0;
        busy_err = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (dif.ready) begin
                got = 1'b1;
            end else begin
                if (!dif.busy) busy_err++;
                if (poke && (lat == 10)) begin
                    dif.start = 1'b1;
                    dif.op1   = ~a;
                    dif.op2   = 64'd5;
                end else begin
                    dif.start = 1'b0;
                end
            end
        end
        dif.start = 1'b0;
        e = sb.pop_front();
        chk({tag, "_ready_seen"}, {63'b0, got}, 64'd1);
        chk({tag, "_busy_run"}, 64'(busy_err), 64'd0);
        chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
        chk({tag, "_quo"}, dif.quo, e.q);
        chk({tag, "_rem"}, dif.rem, e.r);
        chk({tag, "_busy_done"}, {63'b0, dif.busy}, 64'd0);
        last_q = e.q;
        last_r = e.r;
    endtask

    initial begin
        int rdy_cnt;
        rst           = 1'b0;
        dif.start     = 1'b1;
        dif.op1       = 64'd5;
        dif.op2       = 64'd1;
        dif.is_signed = 1'b0;
        dif.is_word   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'b0, dif.busy}, 64'd0);
        chk("rst_ready", {63'b0, dif.ready}, 64'd0);
        chk("rst_quo", dif.quo, 64'd0);
        chk("rst_rem", dif.rem, 64'd0);
        @(negedge clk);
        dif.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        run_op("divu", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65, 1'b1);
        run_op("b2b", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, 65, 1'b0);
        run_op("div_neg7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
        run_op("div_7_neg2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65, 1'b0);
        run_op("divu_big", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 1'b0, 1'b0,
               64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 65, 1'b1);
        run_op("div_zero", 64'h1234, 64'd0, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, 1'b0);
        run_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               64'h8000_0000_0000_0000, 64'd0, 1, 1'b0);
        run_op("divw_ovf", 64'hDEAD_BEEF_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
               64'hFFFF_FFFF_8000_0000, 64'd0, 1, 1'b0);
        run_op("divuw", 64'hDEAD_BEEF_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1,
               64'd0, 64'hFFFF_FFFF_8000_0000, 33, 1'b0);
        run_op("divw_neg20_3", 64'h1234_5678_FFFF_FFEC, 64'hCAFE_0000_0000_0003, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b0);

        // Reset partway through a 64-bit run: the request must vanish silently.
        @(negedge clk);
        dif.start     = 1'b1;
        dif.op1       = 64'd100;
        dif.op2       = 64'd7;
        dif.is_signed = 1'b0;
        dif.is_word   = 1'b0;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", {63'b0, dif.busy}, 64'd0);
        chk("midrst_ready", {63'b0, dif.ready}, 64'd0);
        chk("midrst_quo", dif.quo, 64'd0);
        chk("midrst_rem", dif.rem, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (dif.ready) rdy_cnt++;
        end
        chk("midrst_no_ready", 64'(rdy_cnt), 64'd0);
        chk("midrst_idle", {63'b0, dif.busy}, 64'd0);
        chk("midrst_quo_after", dif.quo, 64'd0);
        last_q = '0;
        last_r = '0;

        run_op("post_rst", 64'd50, 64'd6, 1'b0, 1'b0, 64'd8, 64'd2, 65, 1'b0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_int_div.md
Name: seq_int_div

Overview:
Iterative restoring radix-2 integer divider core. It is the responder side of the start/ready handshake used by the stage-3 divide execution unit.
- Accepts one 64-bit divide request on a `start` pulse.
- Produces quotient and remainder together, with RISC-V M-extension semantics (DIV/DIVU/REM/REMU and the W variants).
- The EU wrapper picks `quo` or `rem` when `ready` pulses.

Parameters:
XLEN, 64, operand/result width; word mode operates on the low XLEN/2 bits.

Ports:
clk        input   1     clock, all state updates on rising edge
rst        input   1     synchronous reset, active-low (rst=0 resets on clk edge)
start      input   1     request strobe; accepted only when busy=0
op1        input   XLEN  dividend
op2        input   XLEN  divisor
is_signed  input   1     1: signed (DIV/REM/DIVW/REMW), 0: unsigned
is_word    input   1     1: 32-bit W op on op1[31:0]/op2[31:0]
busy       output  1     high while a request is in flight
ready      output  1     one-cycle pulse; quo/rem valid
quo        output  XLEN  quotient, held until next accepted start
rem        output  XLEN  remainder, held until next accepted start

Behaviour:
- Reset (rst=0 at edge), also mid-operation: state=IDLE, busy=0, ready=0, quo=0, rem=0, iteration count=0. The in-flight request is discarded and ready is never raised for it.
- States: IDLE, CALC, FIX.
- IDLE: when start=1 at edge E0, latch op1, op2, is_signed and is_word, and set busy=1.
  - Word mode: operands are op*[31:0], sign- or zero-extended per is_signed.
  - Signed mode: capture sign bits and convert operands to magnitudes.
- Special cases, decided at E0, go straight to FIX:
  - Divide by zero (effective divisor == 0): quo = all ones; rem = effective dividend.
  - Signed overflow (dividend = most negative, divisor = -1, at the effective width): quo = dividend; rem = 0.
- Normal path: CALC for N iterations, one quotient bit per edge, MSB first. N=64 normally, N=32 in word mode.
  - Each iteration: partial remainder = {prem, next dividend bit}; subtract the divisor magnitude.
  - If non-negative, keep the difference and set the quotient bit to 1; else restore and set it to 0.
- FIX, at edge E0+N+1 (normal) or E0+1 (special case):
  - Sign correction: negate quo if the operand signs differ; rem takes the dividend sign.
  - Word mode: both results are the 32-bit result sign-extended to 64, including DIVUW/REMUW.
  - Register quo/rem, assert ready=1, busy=0, return to IDLE.
- ready timing: high for exactly one cycle and cleared at the next edge, unless a new completion occurs.
- start while busy=1 is ignored; no queuing, and latched operands do not change.
- start=1 in the cycle ready=1 (state IDLE) is accepted (back-to-back). quo/rem stay valid until that request's FIX edge.
- Operand inputs are don't-care except at the accepting edge.
- Latency from accepting edge to ready:
  - 65 cycles for 64-bit ops.
  - 33 cycles for word ops.
  - 1 cycle for div-by-zero or overflow.
- Unsigned mode never triggers the overflow case.
- Invariant for non-special cases: dividend == quo*divisor + rem, with |rem| < |divisor|, at the effective width.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 -> busy=0, ready=0, quo=0, rem=0.
- Unsigned 64-bit: op1=100, op2=7, is_signed=0, is_word=0 -> ready exactly 65 cycles after the accepting edge, quo=14, rem=2. Busy high throughout; start pulses mid-run are ignored.
- Signed 64-bit: op1=-7 (0xFFFF_FFFF_FFFF_FFF9), op2=2 -> quo=-3 (0xFFFF_FFFF_FFFF_FFFD), rem=-1 (0xFFFF_FFFF_FFFF_FFFF). Also op1=7, op2=-2 -> quo=-3, rem=1.
- Special cases: op2=0, op1=0x1234, signed -> ready after 1 cycle, quo=0xFFFF_FFFF_FFFF_FFFF, rem=0x1234. Signed op1=0x8000_0000_0000_0000, op2=-1 -> quo=0x8000_0000_0000_0000, rem=0.
- Word mode: op1=0xDEAD_BEEF_8000_0000, op2=0xFFFF_FFFF, is_word=1:
  - Signed -> latency 1, quo=0xFFFF_FFFF_8000_0000, rem=0.
  - Unsigned (DIVUW) -> latency 33, quo=0, rem=0xFFFF_FFFF_8000_0000.
- Back-to-back and reset mid-run:
  - Issue start in the ready cycle with op1=9, op2=3 -> second ready 65 cycles later, quo=3, rem=0.
  - Drive rst=0 at iteration 20 of a run -> ready never pulses for that request; IDLE state with outputs at 0 follows.
